// File: rtl/rsfq_buff_line_if.sv
// Requester/buffer-line bundle for the RSFQ buffer-line scheduler.
// The scheduler uses the master modport; the requesters and buffer model use the slave modport.
interface rsfq_buff_line_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic            line_a;
  logic            line_q;
  logic            done;
  logic            err;
  logic [ID_W-1:0] done_id;
  logic            busy;

  modport master (
    input  req,
    input  line_q,
    output grant,
    output line_a,
    output done,
    output err,
    output done_id,
    output busy
  );

  modport slave (
    output req,
    output line_q,
    input  grant,
    input  line_a,
    input  done,
    input  err,
    input  done_id,
    input  busy
  );
endinterface

// File: rtl/rsfq_buff_line_scheduler.sv
// Round-robin scheduler sharing one toggle-encoded RSFQ buffer line between NREQ requesters,
// with ack wait, ack timeout, guard gap and a post-reset start-up hold-off.
module rsfq_buff_line_scheduler #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned ACK_TIMEOUT = 6,
  parameter int unsigned STARTUP_CYC = 8
) (
  input logic              clk,
  input logic              rst_n,
  rsfq_buff_line_if.master bus
);
  localparam int unsigned ID_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned MAX_AG  = (ACK_TIMEOUT > GAP_CYC) ? ACK_TIMEOUT : GAP_CYC;
  localparam int unsigned CNT_MAX = (STARTUP_CYC > MAX_AG) ? STARTUP_CYC : MAX_AG;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [ID_W:0]    NREQ_EXT = (ID_W + 1)'(NREQ);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC);
  localparam logic [CNT_W-1:0] START_LD = CNT_W'(STARTUP_CYC);

  typedef enum logic [1:0] {StStartup, StIdle, StWaitAck, StGap} state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] done_id_q, done_id_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            line_a_q, line_a_d;
  logic            q_prev_q, q_prev_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [ID_W-1:0]   off;
  logic [ID_W:0]     sum_sel;
  logic [ID_W:0]     sum_next;
  logic [ID_W-1:0]   sel_id;
  logic [ID_W-1:0]   sel_next;
  logic              req_any;
  logic              q_toggle;

  assign req_any  = |bus.req;
  assign q_toggle = (bus.line_q != q_prev_q);

  // Rotate requests so bit 0 is the pointer position; the lowest set bit is the winner.
  always_comb begin
    req_dbl = {bus.req, bus.req};
    req_rot = req_dbl[ptr_q +: NREQ];
    off     = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        off = ID_W'(i);
      end
    end
    sum_sel = {1'b0, ptr_q} + {1'b0, off};
    if (sum_sel >= NREQ_EXT) begin
      sum_sel = sum_sel - NREQ_EXT;
    end
    sel_id   = sum_sel[ID_W-1:0];
    sum_next = {1'b0, sel_id} + (ID_W + 1)'(1);
    if (sum_next >= NREQ_EXT) begin
      sum_next = '0;
    end
    sel_next = sum_next[ID_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    done_id_d = done_id_q;
    grant_d   = '0;
    line_a_d  = line_a_q;
    q_prev_d  = q_prev_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      StStartup: begin
        // Line activity here is reset fallout, not a protocol error.
        q_prev_d = bus.line_q;
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StIdle: begin
        if (q_toggle) begin
          err_d    = 1'b1;
          q_prev_d = bus.line_q;
        end
        if (req_any) begin
          grant_d  = NREQ'(1) << sel_id;
          line_a_d = ~line_a_q;
          id_d     = sel_id;
          ptr_d    = sel_next;
          cnt_d    = '0;
          state_d  = StWaitAck;
        end
      end

      StWaitAck: begin
        // cnt_q holds k-1 at edge Ek, so an ack on the timeout edge still wins.
        if (q_toggle) begin
          done_d    = 1'b1;
          done_id_d = id_q;
          q_prev_d  = bus.line_q;
          cnt_d     = GAP_LD;
          state_d   = StGap;
        end else if (cnt_q == ACK_LAST) begin
          err_d     = 1'b1;
          done_id_d = id_q;
          q_prev_d  = bus.line_q;
          cnt_d     = GAP_LD;
          state_d   = StGap;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StGap: begin
        if (q_toggle) begin
          err_d    = 1'b1;
          q_prev_d = bus.line_q;
        end
        if (cnt_q <= CNT_W'(1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = StStartup;
        cnt_d   = START_LD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StStartup;
      cnt_q     <= START_LD;
      ptr_q     <= '0;
      id_q      <= '0;
      done_id_q <= '0;
      grant_q   <= '0;
      line_a_q  <= 1'b0;
      q_prev_q  <= bus.line_q;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      done_id_q <= done_id_d;
      grant_q   <= grant_d;
      line_a_q  <= line_a_d;
      q_prev_q  <= q_prev_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.line_a  = line_a_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.done_id = done_id_q;
  assign bus.busy    = (state_q != StIdle);

  a_done_err_excl : assert property (@(posedge clk) !(done_q && err_q));
  a_grant_onehot0 : assert property (@(posedge clk) $onehot0(grant_q));
  a_grant_issue   : assert property (@(posedge clk) (grant_q != '0) |-> (state_q == StWaitAck));

endmodule

// File: doc/rsfq_buff_line_scheduler.md
Name: rsfq_buff_line_scheduler

Overview:
Clocked scheduler that shares one RSFQ buffer line between NREQ requesters. The line uses toggle encoding: each edge on a is one pulse, and each edge on q is one delivered pulse. The block grants round-robin and issues one pulse at a time by toggling line_a. It waits for the matching line_q toggle, then enforces a guard gap that covers the buffer's critical time before the next issue. It also holds off all issue after reset for a start-up window, matching the cell's undefined state before begin_time.

Parameters:
NREQ, 4, number of requesters (2..16); ID_W = clog2(NREQ), derived.
GAP_CYC, 2, guard cycles after ack/timeout before returning to IDLE (>=1).
ACK_TIMEOUT, 6, cycles after issue within which a line_q toggle must be seen (>=1).
STARTUP_CYC, 8, cycles after reset release before the first issue is allowed (>=0).

Ports:
clk  input  1  single clock; all state updates on posedge clk.
rst_n  input  1  synchronous reset, active-low.
req  input  NREQ  per-requester pulse request; level, held until granted.
grant  output  NREQ  one-hot, one-cycle pulse marking the issue cycle.
line_a  output  1  toggle-encoded drive to buffer input a.
line_q  input  1  buffer output q; synchronous to clk.
done  output  1  one-cycle pulse: issued pulse delivered.
err  output  1  one-cycle pulse: ack timeout or spurious line_q toggle.
done_id  output  ID_W  requester index of the last done or timeout.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n=0 at an edge):
  - line_a=0, grant=0, done=0, err=0, done_id=0.
  - rr pointer=0, state=STARTUP, counter=STARTUP_CYC, q_prev<=line_q.
  - Forcing line_a to 0 mid-operation can itself produce one buffer edge. This is deliberate; STARTUP absorbs the resulting line_q toggle.
- STARTUP:
  - Decrement the counter each edge; move to IDLE on the edge after it reaches 0. STARTUP_CYC=0 means IDLE on the first edge after release.
  - line_q toggles are ignored: q_prev tracks line_q and err stays 0.
  - No grants.
- IDLE:
  - When req!=0, select the first set bit at or after the pointer, wrapping modulo NREQ.
  - On the same edge: grant=onehot(id) for one cycle, line_a toggles, id is latched, pointer=(id+1) mod NREQ, timer=0, state->WAIT_ACK.
  - req=0: no action.
  - A req dropped before grant is not served.
- WAIT_ACK (issue edge = E0; k counts edges after E0):
  - At edge Ek, if line_q!=q_prev: done=1, done_id=id, q_prev<=line_q, counter=GAP_CYC, state->GAP.
  - Else, if k==ACK_TIMEOUT: err=1, done_id=id, q_prev<=line_q (resync), state->GAP.
  - An ack at k==ACK_TIMEOUT wins over timeout (done, no err).
  - req changes are ignored.
- GAP:
  - Decrement the counter; state->IDLE at edge Ek+GAP_CYC.
  - Earliest next issue is Ek+GAP_CYC+1, so issue-to-issue spacing = k+GAP_CYC+1 cycles.
- Spurious toggles: line_q!=q_prev in IDLE or GAP gives err=1 for one cycle and q_prev<=line_q.
  - done_id is unchanged and no done is produced.
  - An issue may still happen on that same IDLE edge.
- Output timing:
  - done and err are never both 1.
  - grant is zero except on issue edges.
  - At most one outstanding pulse at any time.
- Pointer: advances only on grant; unaffected by timeouts or errors.

Test Plan:
- Start-up hold-off: STARTUP_CYC=8, req=0001 from reset, rst_n released at edge R.
  - No grant through R+8; grant=0001 and line_a 0->1 at R+9; busy=1 from R+9.
- Round-robin throughput: req=1111 held, buffer echoes line_a with k=2, GAP_CYC=2.
  - Grants 0001,0010,0100,1000,0001, spaced 5 cycles apart.
  - done after each grant with done_id 0,1,2,3,0.
- Timeout: line_q held constant, ACK_TIMEOUT=6, issue at E0.
  - err at E6 with done_id=issued id; done never asserted; next grant at E6+GAP_CYC+1.
- Ack/timeout tie: line_q toggles exactly at k=6 with ACK_TIMEOUT=6 -> done=1, err=0.
- Spurious and pointer wrap: req=0100 served (pointer->3), then toggle line_q in IDLE -> one err, done_id stays 2.
  - Then req=0011 -> grant 0001 before 0010.
- Reset mid-op: rst_n low for one edge during WAIT_ACK.
  - All outputs return to reset values; line_a=0.
  - The line_q toggle caused by the reset during STARTUP raises no err.
  - Normal issue resumes after STARTUP_CYC.
